// File: rtl/ifq_buf.sv
// ifq_buf - instruction fetch queue between fetch and decode.
//
// Holds fetched {inst, pc, nxt_pc} entries in a circular buffer and hands
// them to decode in order over a valid/ready handshake. Fetch is stalled only
// when the queue is full; a flush (redirect) discards every held entry.
//
// Optional build macro IFQ_BYPASS_EN: when defined, an entry offered to an
// empty queue is shown on the outputs in the same cycle and, if decode takes
// it immediately, is never written. When undefined, the outputs come from
// registered state only (one cycle fetch-to-decode latency).
//
// Parameters:
//   DEPTH     number of entries (power of 2, >= 2)
//   NOP_INST  instruction presented while the queue is empty
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_flush       kill all entries (priority over push/pop)
//   i_vld, i_inst, i_pc, i_nxt_pc   entry offered by fetch
//   o_rdy         queue not full (registered state only)
//   o_vld, o_inst, o_pc, o_nxt_pc   head entry for decode
//   i_rdy         decode accepts the head entry
//   o_count       current occupancy, 0..DEPTH
module ifq_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_vld,
  input  logic [31:0]              i_inst,
  input  logic [31:0]              i_pc,
  input  logic [31:0]              i_nxt_pc,
  output logic                     o_rdy,
  output logic                     o_vld,
  output logic [31:0]              o_inst,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_nxt_pc,
  input  logic                     i_rdy,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Pointers carry one extra wrap bit above the index bits.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] nxt_mem  [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic bypass;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign o_rdy   = ~full;
  assign o_count = wr_ptr - rd_ptr;

`ifdef IFQ_BYPASS_EN
  // An entry offered to an empty queue and taken by decode in the same cycle
  // passes straight through and never touches storage or pointers.
  assign bypass = empty & i_vld & i_rdy & ~i_flush;
`else
  assign bypass = 1'b0;
`endif

  assign push = i_vld & ~full & ~i_flush & ~bypass;
  assign pop  = ~empty & i_rdy & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is not reset; entries are only observable between the pointers.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      inst_mem[wr_ptr[AW-1:0]] <= i_inst;
      pc_mem[wr_ptr[AW-1:0]]   <= i_pc;
      nxt_mem[wr_ptr[AW-1:0]]  <= i_nxt_pc;
    end
  end

  always_comb begin
    o_vld    = 1'b0;
    o_inst   = NOP_INST;
    o_pc     = '0;
    o_nxt_pc = '0;
    if (!empty) begin
      o_vld    = 1'b1;
      o_inst   = inst_mem[rd_ptr[AW-1:0]];
      o_pc     = pc_mem[rd_ptr[AW-1:0]];
      o_nxt_pc = nxt_mem[rd_ptr[AW-1:0]];
    end
`ifdef IFQ_BYPASS_EN
    else if (i_vld && !i_flush) begin
      o_vld    = 1'b1;
      o_inst   = i_inst;
      o_pc     = i_pc;
      o_nxt_pc = i_nxt_pc;
    end
`endif
  end

endmodule

// File: tb/tb_ifq_buf.sv
module tb_ifq_buf;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        vld;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] nxt_pc;
  logic        rdy_o;
  logic        vld_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] nxt_o;
  logic        rdy_i;
  logic [2:0]  count;

  ifq_buf #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_flush  (flush),
    .i_vld    (vld),
    .i_inst   (inst),
    .i_pc     (pc),
    .i_nxt_pc (nxt_pc),
    .o_rdy    (rdy_o),
    .o_vld    (vld_o),
    .o_inst   (inst_o),
    .o_pc     (pc_o),
    .o_nxt_pc (nxt_o),
    .i_rdy    (rdy_i),
    .o_count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] nxt;
  } entry_t;

  entry_t exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return 32'hA000_0000 ^ p;
  endfunction

  // Monitor: every handshake decode completes must match the oldest expected entry.
  always @(negedge clk) begin
    if (vld_o === 1'b1 && rdy_i && !flush && !rst) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop_pc", pc_o, 32'hFFFF_FFFF);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("pop_inst", inst_o, e.inst);
        chk("pop_pc", pc_o, e.pc);
        chk("pop_nxt_pc", nxt_o, e.nxt);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] p, input bit expect_accept);
    vld    = 1'b1;
    pc     = p;
    inst   = inst_of(p);
    nxt_pc = p + 32'd4;
    if (expect_accept) exp_q.push_back('{inst_of(p), p, p + 32'd4});
  endtask

  task automatic idle_in();
    vld    = 1'b0;
    pc     = 32'hDEAD_BEEF;
    inst   = 32'hDEAD_BEEF;
    nxt_pc = 32'hDEAD_BEEF;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; rdy_i = 1'b0;
    idle_in();
    step(); step();
    rst = 1'b0;
    step();

    // Reset / idle state
    chk("rst_vld", 32'(vld_o), 32'd0);
    chk("rst_rdy", 32'(rdy_o), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_nxt_pc", nxt_o, 32'd0);

    // Fill to full with decode stalled
    for (int unsigned k = 0; k < 4; k++) begin
      offer(32'(4 * k), 1'b1);
      step();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_rdy", 32'(rdy_o), 32'd0);
    chk("full_head_pc", pc_o, 32'h0);
    offer(32'h10, 1'b0);
    step();
    chk("full_reject_count", 32'(count), 32'd4);
    idle_in();
    rdy_i = 1'b1;
    for (int unsigned k = 0; k < 4; k++) step();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_vld", 32'(vld_o), 32'd0);
    chk("drain_inst", inst_o, NOP);

    // Streaming: one in, one out each cycle
    for (int unsigned k = 0; k < 20; k++) begin
      offer(32'(4 * k), 1'b1);
      step();
`ifdef IFQ_BYPASS_EN
      chk("stream_count", 32'(count), 32'd0);
`else
      chk("stream_count", 32'(count), 32'd1);
`endif
    end
    idle_in();
    step();
    chk("stream_end_count", 32'(count), 32'd0);
    chk("stream_end_vld", 32'(vld_o), 32'd0);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush with a simultaneous push
    rdy_i = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      offer(32'h20 + 32'(4 * k), 1'b1);
      step();
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    offer(32'h100, 1'b0);
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
    idle_in();
    chk("flush_vld", 32'(vld_o), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_rdy", 32'(rdy_o), 32'd1);
    chk("flush_inst", inst_o, NOP);
    offer(32'h200, 1'b1);
    step();
    idle_in();
    chk("post_flush_head_pc", pc_o, 32'h200);
    chk("post_flush_count", 32'(count), 32'd1);
    rdy_i = 1'b1;
    step();
    rdy_i = 1'b0;
    chk("post_flush_drained", 32'(count), 32'd0);

    // Flush while empty is harmless
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("empty_flush_count", 32'(count), 32'd0);
    chk("empty_flush_rdy", 32'(rdy_o), 32'd1);

    // Full queue, same-cycle pop and offer: pop only
    for (int unsigned k = 0; k < 4; k++) begin
      offer(32'h30 + 32'(4 * k), 1'b1);
      step();
    end
    chk("full2_rdy", 32'(rdy_o), 32'd0);
    offer(32'h40, 1'b0);
    rdy_i = 1'b1;
    step();
    idle_in();
    rdy_i = 1'b0;
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_rdy", 32'(rdy_o), 32'd1);
    chk("full_pop_head", pc_o, 32'h34);
    rdy_i = 1'b1;
    for (int unsigned k = 0; k < 3; k++) step();
    rdy_i = 1'b0;
    chk("full_pop_drained", 32'(count), 32'd0);

    // Offer to empty queue with decode ready
    rdy_i  = 1'b1;
    vld    = 1'b1;
    inst   = 32'h00500093;
    pc     = 32'h40;
    nxt_pc = 32'h44;
    exp_q.push_back('{32'h00500093, 32'h40, 32'h44});
    #1;
`ifdef IFQ_BYPASS_EN
    chk("byp_vld", 32'(vld_o), 32'd1);
    chk("byp_inst", inst_o, 32'h00500093);
    chk("byp_pc", pc_o, 32'h40);
    step();
    idle_in();
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("nobyp_vld", 32'(vld_o), 32'd0);
    chk("nobyp_inst", inst_o, NOP);
    step();
    idle_in();
    chk("nobyp_count", 32'(count), 32'd1);
    chk("nobyp_head_inst", inst_o, 32'h00500093);
    step();
`endif
    rdy_i = 1'b0;
    chk("byp_end_count", 32'(count), 32'd0);

    // Reset mid-stream discards entries
    offer(32'h500, 1'b1);
    step();
    offer(32'h504, 1'b1);
    step();
    idle_in();
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_vld", 32'(vld_o), 32'd0);
    chk("mid_rst_rdy", 32'(rdy_o), 32'd1);

    step();
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ifq_buf.md
Name: ifq_buf

Overview:
- Instruction fetch queue between the fetch stage (with its imem read port) and the decode stage.
- Captures each valid fetched instruction together with its pc and nxt_pc, and presents them in order to decode over a valid/ready handshake.
- Decouples decode stalls from fetch: fetch is back-pressured only when the queue is full.
- Discards all held entries on a pipeline flush (branch/jump redirect).

Parameters:
- DEPTH, 4, number of entries; power of 2, minimum 2.
- NOP_INST, 32'h00000013, instruction driven on o_inst when the queue is empty (addi x0,x0,0).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_flush  in  1  redirect from fetch; kill all entries
- i_vld  in  1  fetch offers an entry this cycle
- i_inst  in  32  imem read data for the offered entry
- i_pc  in  32  pc of the offered entry
- i_nxt_pc  in  32  sequential next pc of the offered entry
- o_rdy  out  1  queue can accept an entry (not full)
- o_vld  out  1  head entry valid for decode
- o_inst  out  32  head instruction
- o_pc  out  32  head pc
- o_nxt_pc  out  32  head nxt_pc
- i_rdy  in  1  decode accepts the head entry
- o_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Interface: reset i_rst, synchronous, active-high; clock i_clk.
- Storage is a circular buffer of DEPTH entries, each {inst, pc, nxt_pc}.
- Read and write pointers are $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- push = i_vld & o_rdy & ~i_flush. Entry is written at wr_ptr; wr_ptr increments modulo 2*DEPTH.
- pop = o_vld & i_rdy & ~i_flush. rd_ptr increments.
- Push and pop may occur in the same cycle; the count is then unchanged.
- o_rdy = ~full. It depends only on registered state, never on i_rdy. When full, a same-cycle pop does not allow a push.
- o_vld = ~empty. o_inst, o_pc and o_nxt_pc are a combinational read of the head entry.
- When empty: o_inst = NOP_INST, o_pc = 0, o_nxt_pc = 0.
- Latency (macro off): an entry pushed at edge N is visible on the outputs from edge N onward, i.e. one cycle after it is offered. Minimum fill-to-drain latency is 1 cycle.
- Flush:
  - Both pointers and the count go to 0 at the next edge.
  - Any same-cycle push or pop is ignored.
  - o_vld = 0 in the cycle after flush.
  - A flush while empty is harmless.
- Flush has priority over push and pop. Reset has priority over everything.
- Values on i_inst, i_pc and i_nxt_pc are don't-care when i_vld = 0.
- Order is strictly FIFO. No entry is dropped or duplicated except by flush.
- Count arithmetic:
  - o_count = wr_ptr - rd_ptr, taken modulo 2*DEPTH; range 0..DEPTH.
  - Pointer wrap from 2*DEPTH-1 to 0 is seamless.
- Reset values: pointers 0, o_count 0, o_vld 0, o_rdy 1, o_inst NOP_INST, o_pc 0, o_nxt_pc 0. Storage contents are not reset.
- Reset asserted mid-stream discards all entries exactly like a flush.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When empty and i_vld & ~i_flush, the outputs show the incoming entry combinationally and o_vld = 1 in the same cycle.
  - If i_rdy is also 1, the entry is consumed and not written; pointers are unchanged.
  - If i_rdy = 0, the entry is written as a normal push.
  - Bypass gives 0-cycle latency.
- Undefined: no combinational path from i_* data to o_*; 1-cycle latency as above.

Test Plan:
- Reset, then idle -> o_vld=0, o_rdy=1, o_count=0, o_inst=32'h00000013.
- Push pc 0x0,0x4,0x8,0xC with i_rdy=0 -> o_count=4, o_rdy=0; a 5th offer (pc 0x10) is not accepted; then i_rdy=1 drains 0x0,0x4,0x8,0xC in order with matching nxt_pc.
- Continuous streaming with i_vld=1, i_rdy=1 for 20 cycles (pc 0x0..0x4C) -> steady o_count=1 (macro off), every pc is seen exactly once in order, and pointers wrap cleanly.
- Queue holding 3 entries, i_flush=1 with a simultaneous push of pc 0x100 -> next cycle o_vld=0, o_count=0; pc 0x100 never appears; a subsequent push of pc 0x200 appears as head.
- Full queue with i_rdy=1 and i_vld=1 in the same cycle -> one pop, no push, o_count=3, o_rdy=1 the next cycle.
- IFQ_BYPASS_EN defined, empty queue, push inst 0x00500093 at pc 0x40 with i_rdy=1 -> same cycle o_vld=1, o_inst=0x00500093, o_pc=0x40; o_count stays 0.
